// File: rtl/regfile_multiport.sv
// Multiported register bank: two registered read ports with optional write-first bypass,
// two combinational read ports, a debug read port, one write port and a sequential clear engine.
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] dataa,
    output logic [DATA_WIDTH-1:0] datab,
    output logic [DATA_WIDTH-1:0] ass_dataa,
    output logic [DATA_WIDTH-1:0] ass_datab,
    input  logic                  enc,
    input  logic [ADDR_WIDTH-1:0] addrc,
    input  logic [DATA_WIDTH-1:0] datac,
    input  logic [ADDR_WIDTH-1:0] addrout,
    output logic [DATA_WIDTH-1:0] regout,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] next_a;
    logic [DATA_WIDTH-1:0] next_b;

    // Writes are dropped while sweeping and, when register 0 is hardwired, to address 0.
    assign wr_accept = enc && (state != SWEEP) && !((ZERO_REG != 0) && (addrc == '0));

    assign ass_dataa = ((ZERO_REG != 0) && (addra == '0))   ? '0 : mem[addra];
    assign ass_datab = ((ZERO_REG != 0) && (addrb == '0))   ? '0 : mem[addrb];
    assign regout    = ((ZERO_REG != 0) && (addrout == '0)) ? '0 : mem[addrout];

    // Only accepted writes are forwarded; the sweep never bypasses.
    assign next_a = ((BYPASS != 0) && wr_accept && (addrc == addra)) ? datac : ass_dataa;
    assign next_b = ((BYPASS != 0) && wr_accept && (addrc == addrb)) ? datac : ass_datab;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == SWEEP) begin
            mem[ptr[ADDR_WIDTH-1:0]] <= '0;
        end else if (wr_accept) begin
            mem[addrc] <= datac;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dataa <= '0;
            datab <= '0;
        end else begin
            dataa <= next_a;
            datab <= next_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if ((state == IDLE) && clr_start) begin
            ptr <= '0;
        end else if (state == SWEEP) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_start) state_next = SWEEP;
            SWEEP:   if (ptr == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        clr_done = 1'b0;
        case (state)
            SWEEP:   busy = 1'b1;
            DONE:    clr_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default 32x32 instance plus a small 16-bit, 8-entry
// instance with register 0 ordinary and bypass disabled.
module tb_regfile_multiport;

    logic        clock = 1'b0;
    logic        reset;

    logic [4:0]  addra, addrb, addrc, addrout;
    logic [31:0] dataa, datab, ass_dataa, ass_datab, datac, regout;
    logic        enc, clr_start, busy, clr_done;

    logic [2:0]  s_addra, s_addrb, s_addrc, s_addrout;
    logic [15:0] s_dataa, s_datab, s_ass_dataa, s_ass_datab, s_datac, s_regout;
    logic        s_enc, s_clr_start, s_busy, s_clr_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    regfile_multiport dut (
        .clock(clock), .reset(reset),
        .addra(addra), .addrb(addrb), .dataa(dataa), .datab(datab),
        .ass_dataa(ass_dataa), .ass_datab(ass_datab),
        .enc(enc), .addrc(addrc), .datac(datac),
        .addrout(addrout), .regout(regout),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
    );

    regfile_multiport #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)
    ) dut_small (
        .clock(clock), .reset(reset),
        .addra(s_addra), .addrb(s_addrb), .dataa(s_dataa), .datab(s_datab),
        .ass_dataa(s_ass_dataa), .ass_datab(s_ass_datab),
        .enc(s_enc), .addrc(s_addrc), .datac(s_datac),
        .addrout(s_addrout), .regout(s_regout),
        .clr_start(s_clr_start), .busy(s_busy), .clr_done(s_clr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        addra = '0; addrb = '0; addrc = '0; addrout = '0; datac = '0;
        enc = 1'b0; clr_start = 1'b0;
        s_addra = '0; s_addrb = '0; s_addrc = '0; s_addrout = '0; s_datac = '0;
        s_enc = 1'b0; s_clr_start = 1'b0;

        repeat (2) tick();
        check("rst_dataa", dataa, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, clr_done}, 32'h0);
        check("rst_regout", regout, 32'h0);
        check("rst_small_dataa", s_dataa, 32'h0);
        reset = 1'b1;
        tick();

        // Basic write then registered and combinational read
        enc = 1'b1; addrc = 5'd5; datac = 32'hDEADBEEF;
        tick();
        enc = 1'b0; addra = 5'd5; #1;
        check("ass_dataa_r5", ass_dataa, 32'hDEADBEEF);
        tick();
        check("dataa_r5", dataa, 32'hDEADBEEF);

        // Write-first bypass on port A and port B
        enc = 1'b1; addrc = 5'd7; datac = 32'h12345678; addra = 5'd7; addrb = 5'd7;
        tick();
        enc = 1'b0;
        check("bypass_dataa", dataa, 32'h12345678);
        check("bypass_datab", datab, 32'h12345678);

        // Register 0 hardwired: write dropped, not forwarded
        enc = 1'b1; addrc = 5'd0; datac = 32'hFFFFFFFF; addra = 5'd0; addrout = 5'd0;
        tick();
        enc = 1'b0;
        check("zero_dataa", dataa, 32'h0);
        check("zero_regout", regout, 32'h0);

        // Fill r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            enc = 1'b1; addrc = 5'(i); datac = 32'(i);
            tick();
        end
        enc = 1'b0;
        for (int i = 1; i < 32; i++) begin
            addrout = 5'(i); #1;
            check("fill_regout", regout, 32'(i));
        end

        // Full sweep; a write to r9 late in the sweep must be lost
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 20) begin
                enc = 1'b1; addrc = 5'd9; datac = 32'h99;
            end else begin
                enc = 1'b0;
            end
            tick();
        end
        enc = 1'b0;
        check("sweep_busy_cycles", 32'(n), 32'd32);
        check("sweep_done_pulse", {31'b0, clr_done}, 32'h1);
        tick();
        check("sweep_done_clear", {31'b0, clr_done}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            addrout = 5'(i); #1;
            check("sweep_regout", regout, 32'h0);
        end

        // Simultaneous write and clr_start: write lands, then sweep overwrites it
        enc = 1'b1; addrc = 5'd3; datac = 32'h33; clr_start = 1'b1; addrout = 5'd3;
        tick();
        enc = 1'b0; clr_start = 1'b0;
        check("simul_write", regout, 32'h33);
        check("simul_busy", {31'b0, busy}, 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("simul_cleared", regout, 32'h0);
        tick();

        // Reset in mid-sweep
        enc = 1'b1; addrc = 5'd20; datac = 32'hA5A5A5A5; addrout = 5'd20;
        tick();
        enc = 1'b0; clr_start = 1'b1;
        check("r20_written", regout, 32'hA5A5A5A5);
        tick();
        clr_start = 1'b0;
        repeat (10) tick();
        check("mid_r20_intact", regout, 32'hA5A5A5A5);
        reset = 1'b0; #1;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_r20", regout, 32'h0);
        n = 0;
        repeat (3) begin
            tick();
            if (clr_done !== 1'b0) n++;
        end
        check("mid_rst_no_done", 32'(n), 32'd0);
        reset = 1'b1;
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("restart_busy", {31'b0, busy}, 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("restart_cycles", 32'(n), 32'd32);
        check("restart_done", {31'b0, clr_done}, 32'h1);
        tick();

        // Small instance: no bypass, old value read on the write edge
        s_enc = 1'b1; s_addrc = 3'd7; s_datac = 16'h1234; s_addra = 3'd7;
        tick();
        s_enc = 1'b0;
        check("nobyp_dataa_old", s_dataa, 32'h0);
        check("nobyp_ass_dataa", s_ass_dataa, 32'h1234);
        tick();
        check("nobyp_dataa_new", s_dataa, 32'h1234);

        // Small instance: register 0 ordinary
        s_enc = 1'b1; s_addrc = 3'd0; s_datac = 16'hFFFF; s_addrout = 3'd0; s_addra = 3'd0;
        tick();
        s_enc = 1'b0;
        check("r0_ordinary_regout", s_regout, 32'hFFFF);
        tick();
        check("r0_ordinary_dataa", s_dataa, 32'hFFFF);

        // Small instance: 8-cycle sweep
        s_enc = 1'b1; s_addrc = 3'd7; s_datac = 16'hBEEF; s_addrb = 3'd7;
        tick();
        s_enc = 1'b0;
        check("small_r7", s_ass_datab, 32'hBEEF);
        s_clr_start = 1'b1;
        tick();
        s_clr_start = 1'b0;
        n = 0;
        while (s_busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check("small_busy_cycles", 32'(n), 32'd8);
        check("small_done", {31'b0, s_clr_done}, 32'h1);
        tick();
        for (int i = 0; i < 8; i++) begin
            s_addrout = 3'(i); #1;
            check("small_sweep_regout", s_regout, 32'h0);
        end
        check("small_datab_cleared", s_datab, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor to the processor register bank. Width, depth and register-zero handling are configurable. Provides two registered read ports with write-first bypass, two combinational read ports, one debug read port and one write port. Adds a sequential clear engine that sweeps the array one entry per cycle, giving the datapath a full register wipe without a global reset.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary
BYPASS, 1, 1 = registered read ports forward same-cycle write data; 0 = read old contents

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears the array, outputs and FSM
addra  in  ADDR_WIDTH  read address, port A
addrb  in  ADDR_WIDTH  read address, port B
dataa  out  DATA_WIDTH  registered read data, port A
datab  out  DATA_WIDTH  registered read data, port B
ass_dataa  out  DATA_WIDTH  combinational read data, port A
ass_datab  out  DATA_WIDTH  combinational read data, port B
enc  in  1  write enable
addrc  in  ADDR_WIDTH  write address
datac  in  DATA_WIDTH  write data
addrout  in  ADDR_WIDTH  debug read address
regout  out  DATA_WIDTH  combinational debug read data
clr_start  in  1  request a sequential clear (sampled only in IDLE)
busy  out  1  high while a sweep is in progress
clr_done  out  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset low, asynchronous: all entries = 0; dataa = datab = 0; FSM = IDLE; clear pointer = 0; busy = 0; clr_done = 0. The combinational outputs follow the cleared array.
- Write: on a rising edge with enc = 1 and the FSM not in SWEEP, registers[addrc] <= datac.
  - With ZERO_REG = 1, a write to address 0 is dropped.
  - During SWEEP, enc is ignored and the data is lost. Upstream must stall while busy = 1.
- Registered read: dataa/datab <= contents of addra/addrb, 1-cycle latency.
  - With BYPASS = 1 and a same-edge accepted write to the read address, the output takes datac (write-first).
  - With BYPASS = 0, the output takes the pre-write value.
  - A dropped write (address 0 with ZERO_REG = 1, or any write during SWEEP) is never forwarded.
- Combinational read: ass_dataa, ass_datab and regout reflect current array contents with no bypass. Address 0 returns 0 when ZERO_REG = 1.
- FSM states:
  - IDLE: clr_start = 1 -> SWEEP, pointer = 0.
  - SWEEP: each edge writes registers[pointer] <= 0 and increments the pointer; after writing 2**ADDR_WIDTH-1 -> DONE.
  - DONE: one cycle -> IDLE.
- FSM outputs:
  - busy = 1 exactly in SWEEP, which lasts 2**ADDR_WIDTH cycles.
  - clr_done = 1 exactly in DONE.
  - clr_start is ignored in SWEEP and DONE; no queueing.
- Reads during SWEEP are legal and return the partially cleared contents. On the edge that clears an entry, a registered read of that entry returns the old value (no bypass from the sweep).
- The pointer is ADDR_WIDTH+1 bits wide so the terminal count is detected without wrap ambiguity.
- Reset asserted mid-sweep: the array is fully cleared immediately and the FSM returns to IDLE; no clr_done pulse.
- Simultaneous enc and clr_start in IDLE: the write is committed on that edge and the sweep starts next cycle, so the write is later overwritten by the sweep.
- Registers are held when idle; no X on any output after reset.

Test Plan:
1. Reset release, then write 32'hDEADBEEF to r5 and read addra = 5 on the next cycle -> dataa = 32'hDEADBEEF one cycle later; ass_dataa = 32'hDEADBEEF combinationally.
2. Same-edge enc = 1, addrc = 7, datac = 32'h12345678, addra = 7 -> BYPASS = 1: dataa = 32'h12345678 after the edge; BYPASS = 0: dataa = 0 (old value).
3. ZERO_REG = 1: write 32'hFFFFFFFF to r0 -> regout (addrout = 0) = 0, dataa = 0, no forwarding. ZERO_REG = 0: the same write reads back 32'hFFFFFFFF.
4. Fill r1..r31 with their index, pulse clr_start -> busy high for exactly 32 cycles; clr_done pulses once on cycle 33; then all 32 regout reads = 0. A write to r9 during busy is lost (r9 = 0 afterwards).
5. Start a sweep, assert reset at pointer = 10 with r20 = 32'hA5A5A5A5 -> busy = 0, r20 = 0 immediately, no clr_done, FSM accepts a new clr_start after release.
6. DATA_WIDTH = 16, ADDR_WIDTH = 3: write 16'hBEEF to r7, sweep -> busy lasts 8 cycles, r7 reads 0 afterwards.
